// File: rtl/psum_pkg.sv
// Shared types and helpers for the partial-sum accumulator.
// PSUM_RELU_EN (optional define) enables ReLU clamping in psum_requant.
package psum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int SHIFT_W = 6;
  localparam int SAT_W   = 128;

  // Clip a signed value to a signed range of 'width' bits; 'clipped' flags clipping.
  function automatic logic signed [SAT_W-1:0] sat_to_width(
    input  logic signed [SAT_W-1:0] value,
    input  int unsigned             width,
    output logic                    clipped
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] res;
    hi      = $signed((SAT_W'(1) << (width - 1)) - SAT_W'(1));
    lo      = ~hi;
    clipped = 1'b1;
    if (value > hi) begin
      res = hi;
    end else if (value < lo) begin
      res = lo;
    end else begin
      res     = value;
      clipped = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/psum_requant.sv
// Combinational round-half-up, arithmetic shift, optional ReLU and saturate.
// PSUM_RELU_EN: when defined, negative rounded results are forced to zero.
module psum_requant
  import psum_pkg::*;
#(
  parameter int ACC_WIDTH = 44,
  parameter int OUT_WIDTH = 16
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic        [SHIFT_W-1:0]   shift,
  output logic signed [OUT_WIDTH-1:0] data,
  output logic                        sat
);

  localparam int RW = ACC_WIDTH + 1;

  logic        [SHIFT_W-1:0] eff_shift;
  logic signed [RW-1:0]      ext;
  logic signed [RW-1:0]      rnd;
  logic signed [RW-1:0]      r;
  logic signed [SAT_W-1:0]   wide;

  always_comb begin
    // Shifts beyond ACC_WIDTH all round to zero, so clamping keeps the math exact in RW bits.
    eff_shift = shift;
    if (int'(shift) > ACC_WIDTH) begin
      eff_shift = SHIFT_W'(ACC_WIDTH);
    end
    ext = RW'(acc);
    rnd = '0;
    if (eff_shift != '0) begin
      rnd = $signed(RW'(1) << (eff_shift - SHIFT_W'(1)));
    end
    r = (ext + rnd) >>> eff_shift;
`ifdef PSUM_RELU_EN
    if (r < 0) begin
      r = '0;
    end
`else
`endif
    wide = SAT_W'(r);
    sat  = 1'b0;
    data = OUT_WIDTH'(sat_to_width(wide, OUT_WIDTH, sat));
  end

endmodule

// File: rtl/psum_accumulator.sv
// Sums cfg_passes consecutive MAC partial sums, requantizes, and holds the result on valid/ready.
// PSUM_RELU_EN (optional define) enables ReLU in the requantizer.
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int IN_WIDTH   = 38,
  parameter int MAX_PASSES = 64,
  parameter int ACC_WIDTH  = IN_WIDTH + $clog2(MAX_PASSES),
  parameter int OUT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst_in,
  input  logic [$clog2(MAX_PASSES):0]    cfg_passes,
  input  logic [SHIFT_W-1:0]             cfg_shift,
  input  logic                           in_valid,
  input  logic signed [IN_WIDTH-1:0]     in_psum,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [OUT_WIDTH-1:0]    out_data,
  output logic                           out_sat,
  output logic                           busy
);

  localparam int PW = $clog2(MAX_PASSES) + 1;

  state_t                      state_reg, state_next;
  logic signed [ACC_WIDTH-1:0] acc_reg, acc_next, psum_ext;
  logic        [PW-1:0]        count_reg, count_next;
  logic        [PW-1:0]        passes_reg, passes_eff, passes_cur;
  logic        [SHIFT_W-1:0]   shift_reg, shift_cur;
  logic signed [OUT_WIDTH-1:0] out_data_reg, rq_data;
  logic                        out_sat_reg, rq_sat;
  logic                        accept, first_beat, last_beat;

  always_comb begin
    in_ready   = (state_reg == HOLD) ? out_ready : 1'b1;
    accept     = in_valid && in_ready;
    // Any beat outside ACCUM opens a new group, including the overlap beat in HOLD.
    first_beat = (state_reg != ACCUM);
    passes_eff = cfg_passes;
    if (cfg_passes == '0) begin
      passes_eff = PW'(1);
    end else if (cfg_passes > PW'(MAX_PASSES)) begin
      passes_eff = PW'(MAX_PASSES);
    end
    passes_cur = first_beat ? passes_eff : passes_reg;
    shift_cur  = first_beat ? cfg_shift : shift_reg;
    psum_ext   = ACC_WIDTH'(in_psum);
    count_next = first_beat ? PW'(1) : count_reg + PW'(1);
    acc_next   = first_beat ? psum_ext : acc_reg + psum_ext;
    last_beat  = accept && (count_next == passes_cur);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, ACCUM: begin
        if (accept) state_next = last_beat ? HOLD : ACCUM;
      end
      HOLD: begin
        if (accept)         state_next = last_beat ? HOLD : ACCUM;
        else if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  psum_requant #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_requant (
    .acc   (acc_next),
    .shift (shift_cur),
    .data  (rq_data),
    .sat   (rq_sat)
  );

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      acc_reg      <= '0;
      count_reg    <= '0;
      passes_reg   <= '0;
      shift_reg    <= '0;
      out_data_reg <= '0;
      out_sat_reg  <= 1'b0;
    end else begin
      if (accept) begin
        acc_reg   <= acc_next;
        count_reg <= count_next;
        if (first_beat) begin
          passes_reg <= passes_eff;
          shift_reg  <= cfg_shift;
        end
      end
      if (last_beat) begin
        out_data_reg <= rq_data;
        out_sat_reg  <= rq_sat;
      end
    end
  end

  assign out_valid = (state_reg == HOLD);
  assign busy      = (state_reg != IDLE);
  assign out_data  = out_data_reg;
  assign out_sat   = out_sat_reg;

endmodule
